// File: rtl/mem_bus_arbiter_if.sv
// Two-master memory/LED bus bundle: master request side plus the memory/LED facing side.
interface mem_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          mem_wr_en;
  logic          led_wr_en;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] led_q;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, led_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, bus_addr, bus_wdata, mem_wr_en, led_wr_en
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, led_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, bus_addr, bus_wdata, mem_wr_en, led_wr_en
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin, burst-bounded arbiter sharing data memory and LED register between two masters.
// Optional: define LED_READBACK_EN to return led_q on LED-region reads (otherwise they read 0).
module mem_bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int              BCW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCW-1:0]  BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic [3:0]      REG_MEM    = 4'h0;
  localparam logic [3:0]      REG_LED    = 4'h1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t         state;
  logic           last;
  logic [BCW-1:0] burst_cnt;
  logic [1:0]     rd_pend;
  logic           rd_mem;
`ifdef LED_READBACK_EN
  logic           rd_led;
  logic [DW-1:0]  led_hold;
`endif

  logic           gnt0, gnt1;
  logic           sel_we;
  logic           rd_issue;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic [3:0]     region;

  always_comb begin
    gnt0      = (state == OWN0) && bus.req0;
    gnt1      = (state == OWN1) && bus.req1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = bus.we0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
    end else if (gnt1) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
    region   = sel_addr[AW-1 -: 4];
    rd_issue = (gnt0 || gnt1) && !sel_we;
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.bus_addr  = sel_addr;
  assign bus.bus_wdata = sel_wdata;
  assign bus.mem_wr_en = sel_we && (region == REG_MEM);
  assign bus.led_wr_en = sel_we && (region == REG_LED);
  assign bus.rvalid0   = rd_pend[0];
  assign bus.rvalid1   = rd_pend[1];

  // Memory data arrives one cycle after the address edge, so it is muxed live, not registered.
  always_comb begin
    bus.rdata = '0;
    if (rd_mem)
      bus.rdata = bus.mem_rdata;
`ifdef LED_READBACK_EN
    else if (rd_led)
      bus.rdata = led_hold;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            state     <= last ? OWN0 : OWN1;
            last      <= ~last;
            burst_cnt <= '0;
          end else if (bus.req0) begin
            state     <= OWN0;
            last      <= 1'b0;
            burst_cnt <= '0;
          end else if (bus.req1) begin
            state     <= OWN1;
            last      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        OWN0: begin
          if (!bus.req0 || ((burst_cnt == BURST_LAST) && bus.req1)) begin
            if (bus.req1) begin
              state     <= OWN1;
              last      <= 1'b1;
              burst_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (burst_cnt != BURST_LAST) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        OWN1: begin
          if (!bus.req1 || ((burst_cnt == BURST_LAST) && bus.req0)) begin
            if (bus.req0) begin
              state     <= OWN0;
              last      <= 1'b0;
              burst_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (burst_cnt != BURST_LAST) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend <= '0;
      rd_mem  <= 1'b0;
`ifdef LED_READBACK_EN
      rd_led   <= 1'b0;
      led_hold <= '0;
`endif
    end else begin
      rd_pend <= {gnt1 && !bus.we1, gnt0 && !bus.we0};
      rd_mem  <= rd_issue && (region == REG_MEM);
`ifdef LED_READBACK_EN
      rd_led  <= rd_issue && (region == REG_LED);
      if (rd_issue && (region == REG_LED))
        led_hold <= bus.led_q;
`endif
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: bench-side memory/LED register plus an ownership/memory reference model.
module tb_mem_bus_arbiter;
  localparam int MB = 4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic clock;
  logic reset;

  mem_bus_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_bus_arbiter #(.AW(16), .DW(16), .MAX_BURST(MB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench-side memory and LED register, driven only by the DUT strobes.
  logic [15:0] mem_arr [4096] = '{default: '0};
  logic [15:0] mem_q   = '0;
  logic [15:0] led_reg = '0;
  assign bus.mem_rdata = mem_q;
  assign bus.led_q     = led_reg;

  always @(posedge clock) begin
    if (bus.mem_wr_en) mem_arr[bus.bus_addr[11:0]] <= bus.bus_wdata;
    mem_q <= mem_arr[bus.bus_addr[11:0]];
    if (bus.led_wr_en) led_reg <= bus.bus_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] ref_mem [4096] = '{default: '0};
  logic [15:0] ref_led = '0;
  int          owner   = -1;
  int          last_own = 1;
  int          tenure  = 0;
  logic [1:0]  exp_rv  = '0;
  logic [15:0] exp_rd  = '0;

  // Master stimulus state
  txn_t        q0[$];
  txn_t        q1[$];
  txn_t        cur[2];
  logic [1:0]  active  = '0;
  logic [1:0]  granted = '0;
  int          p_req[2] = '{0, 0};
  logic [1:0]  ghist[$];
  logic [15:0] cap0, cap1;

  function automatic txn_t rand_txn();
    txn_t t;
    t.we   = 1'($urandom_range(0, 1));
    t.data = 16'($urandom);
    case ($urandom_range(0, 3))
      0, 1:    t.addr = {12'h000, 4'($urandom_range(0, 15))};
      2:       t.addr = {4'h1, 12'($urandom_range(0, 3))};
      default: t.addr = {4'($urandom_range(2, 15)), 12'($urandom)};
    endcase
    return t;
  endfunction

  task automatic drive_phase();
    for (int i = 0; i < 2; i++) begin
      if (granted[i]) active[i] = 1'b0;
      granted[i] = 1'b0;
      if (!active[i]) begin
        if (i == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front(); active[0] = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front(); active[1] = 1'b1;
        end else if (int'($urandom_range(0, 99)) < p_req[i]) begin
          cur[i] = rand_txn(); active[i] = 1'b1;
        end
      end
    end
    bus.req0 = active[0]; bus.we0 = cur[0].we; bus.addr0 = cur[0].addr; bus.wdata0 = cur[0].data;
    bus.req1 = active[1]; bus.we1 = cur[1].we; bus.addr1 = cur[1].addr; bus.wdata1 = cur[1].data;
  endtask

  task automatic check_phase();
    logic [1:0]  rq;
    logic        eg0, eg1, w;
    logic [15:0] a, d;
    logic [3:0]  rg;
    int          nxt;
    rq  = active;
    eg0 = (owner == 0) && rq[0];
    eg1 = (owner == 1) && rq[1];
    w = 1'b0; a = '0; d = '0;
    if (eg0) begin w = cur[0].we; a = cur[0].addr; d = cur[0].data; end
    else if (eg1) begin w = cur[1].we; a = cur[1].addr; d = cur[1].data; end
    rg = a[15:12];

    check_val("gnt0", 32'(bus.gnt0), 32'(eg0));
    check_val("gnt1", 32'(bus.gnt1), 32'(eg1));
    check_val("mem_wr_en", 32'(bus.mem_wr_en), 32'((eg0 || eg1) && w && rg == 4'h0));
    check_val("led_wr_en", 32'(bus.led_wr_en), 32'((eg0 || eg1) && w && rg == 4'h1));
    check_val("bus_addr", 32'(bus.bus_addr), 32'(a));
    check_val("bus_wdata", 32'(bus.bus_wdata), 32'(d));
    check_val("rvalid0", 32'(bus.rvalid0), 32'(exp_rv[0]));
    check_val("rvalid1", 32'(bus.rvalid1), 32'(exp_rv[1]));
    if (exp_rv != 2'b00) check_val("rdata", 32'(bus.rdata), 32'(exp_rd));

    ghist.push_back({bus.gnt1, bus.gnt0});
    if (bus.rvalid0) cap0 = bus.rdata;
    if (bus.rvalid1) cap1 = bus.rdata;

    exp_rv = {eg1 && !w, eg0 && !w};
    if ((eg0 || eg1) && !w) begin
      if (rg == 4'h0) exp_rd = ref_mem[a[11:0]];
`ifdef LED_READBACK_EN
      else if (rg == 4'h1) exp_rd = ref_led;
`endif
      else exp_rd = '0;
    end
    if ((eg0 || eg1) && w) begin
      if (rg == 4'h0) ref_mem[a[11:0]] = d;
      else if (rg == 4'h1) ref_led = d;
    end
    granted = {eg1, eg0};

    // Ownership: tie goes to whoever did not own last; a tenure ends after MB grants if contested.
    nxt = owner;
    if (owner < 0) begin
      if (rq == 2'b11) nxt = 1 - last_own;
      else if (rq[0]) nxt = 0;
      else if (rq[1]) nxt = 1;
    end else if (!rq[owner]) begin
      nxt = rq[1 - owner] ? 1 - owner : -1;
    end else begin
      tenure++;
      if (tenure >= MB && rq[1 - owner]) nxt = 1 - owner;
    end
    if (nxt >= 0 && nxt != owner) begin
      last_own = nxt;
      tenure   = 0;
    end
    owner = nxt;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      drive_phase();
      @(negedge clock);
      check_phase();
    end
  endtask

  task automatic clear_stimulus();
    active = '0; granted = '0; p_req = '{0, 0};
    q0.delete(); q1.delete();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    owner = -1; last_own = 1; tenure = 0; exp_rv = '0;
  endtask

  task automatic check_quiet(input string pfx);
    check_val({pfx, "_gnt0"}, 32'(bus.gnt0), 0);
    check_val({pfx, "_gnt1"}, 32'(bus.gnt1), 0);
    check_val({pfx, "_mem_wr_en"}, 32'(bus.mem_wr_en), 0);
    check_val({pfx, "_led_wr_en"}, 32'(bus.led_wr_en), 0);
    check_val({pfx, "_rvalid0"}, 32'(bus.rvalid0), 0);
    check_val({pfx, "_rvalid1"}, 32'(bus.rvalid1), 0);
  endtask

  // Reset asserted mid-cycle while traffic is flowing; outputs must drop before the next edge.
  task automatic mid_reset();
    @(posedge clock); #3;
    reset = 1'b1;
    clear_stimulus();
    #1;
    check_quiet("midrst");
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  int base;
  logic [1:0] exp_g;
  logic [1:0] seq5 [4];

  initial begin
    reset = 1'b1;
    cur[0] = '0; cur[1] = '0;
    cap0 = '0; cap1 = '0;
    clear_stimulus();
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (2) @(posedge clock);
    #1;
    check_quiet("rst");
    check_val("rst_bus_addr", 32'(bus.bus_addr), 0);
    reset = 1'b0;

    // Both masters request continuously: 4-grant alternating tenures, no idle cycles.
    p_req = '{100, 100};
    base = ghist.size();
    run(25);
    for (int k = 0; k < 25; k++) begin
      if (k == 0) exp_g = 2'b00;
      else exp_g = (((k - 1) / MB) % 2 == 0) ? 2'b01 : 2'b10;
      check_val("burst_seq", 32'(ghist[base + k]), 32'(exp_g));
    end
    mid_reset();

    // M0 write then read back from memory.
    q0.push_back('{1'b1, 16'h0010, 16'hBEEF});
    q0.push_back('{1'b0, 16'h0010, 16'h0000});
    cap0 = '0;
    run(6);
    check_val("m0_readback", 32'(cap0), 32'h0000_BEEF);

    // M1 LED write and unmapped write.
    q1.push_back('{1'b1, 16'h1000, 16'h1234});
    q1.push_back('{1'b1, 16'h2000, 16'h5555});
    run(6);

    // LED readback.
    q1.push_back('{1'b1, 16'h1000, 16'h00A5});
    q1.push_back('{1'b0, 16'h1000, 16'h0000});
    cap1 = 16'hFFFF;
    run(6);
`ifdef LED_READBACK_EN
    check_val("led_read", 32'(cap1), 32'h0000_00A5);
`else
    check_val("led_read", 32'(cap1), 32'h0000_0000);
`endif

    // M1 was last owner; simultaneous requests go to M0, then M1 one cycle after M0 drops.
    q1.push_back('{1'b1, 16'h0020, 16'h7777});
    run(4);
    base = ghist.size();
    q0.push_back('{1'b0, 16'h0010, 16'h0000});
    q1.push_back('{1'b0, 16'h0020, 16'h0000});
    run(6);
    seq5 = '{2'b00, 2'b01, 2'b00, 2'b10};
    for (int k = 0; k < 4; k++)
      check_val("tie_seq", 32'(ghist[base + k]), 32'(seq5[k]));

    // Randomized traffic with varying request pressure and one reset in the middle.
    for (int blk = 0; blk < 8; blk++) begin
      p_req = '{int'($urandom_range(20, 100)), int'($urandom_range(20, 100))};
      run(200);
      if (blk == 3) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
